// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader: streams a segmented program/data image into the MIPS32
// core's unified memory, keeps the core halted while loading, then pulses a
// PC load and releases it. Returns to loading when the core reports HALTED.
//
// Ports:
//   clk1, rst            clock, asynchronous active-high reset
//   s_valid/s_ready      input word handshake
//   s_data, s_last       header/body word; s_last marks the end of the image
//   mem_we/addr/wdata    registered memory write port, one strobe per body word
//   cpu_run              core enable (0 holds the core halted)
//   pc_load, pc_value    one-cycle PC load pulse, value ENTRY_PC
//   cpu_halted           core HALTED level, only observed while running
//   words_loaded         body words written in the current image (saturating)
//   err                  sticky framing error
module mips32_prog_loader #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] ENTRY_PC = 32'h0000_0000
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              pc_load,
  output logic [31:0]       pc_value,
  input  logic              cpu_halted,
  output logic [15:0]       words_loaded,
  output logic              err
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_HDR     = 3'd0,
    ST_BODY    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_ERR     = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ADDR_W-1:0]  r_addr;
  logic [CNT_W-1:0]   r_remain;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic               r_cpu_run;
  logic               r_pc_load;
  logic [CNT_W-1:0]   r_words;
  logic               r_err;

  logic               w_ready;
  logic               w_hdr_acc;
  logic               w_body_acc;
  logic [CNT_W-1:0]   w_hdr_count;

  assign w_hdr_count = s_data[31:16];

  // State register
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) r_state <= ST_HDR;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HDR: begin
        if (s_valid) begin
          if (w_hdr_count == '0) begin
            if (s_last) w_state_nxt = ST_RELEASE;
          end else if (s_last) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_state_nxt = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (s_valid) begin
          if (r_remain == CNT_W'(1)) w_state_nxt = s_last ? ST_RELEASE : ST_HDR;
          else if (s_last)           w_state_nxt = ST_ERR;
        end
      end
      ST_RELEASE: w_state_nxt = ST_RUN;
      ST_RUN:     if (cpu_halted) w_state_nxt = ST_HDR;
      ST_ERR:     w_state_nxt = ST_ERR;
      default:    w_state_nxt = ST_HDR;
    endcase
  end

  // Handshake decode from the current state
  always_comb begin
    w_ready    = 1'b0;
    w_hdr_acc  = 1'b0;
    w_body_acc = 1'b0;
    case (r_state)
      ST_HDR: begin
        w_ready   = 1'b1;
        w_hdr_acc = s_valid;
      end
      ST_BODY: begin
        w_ready    = 1'b1;
        w_body_acc = s_valid;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_remain    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_run   <= 1'b0;
      r_pc_load   <= 1'b0;
      r_words     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_mem_we  <= w_body_acc;
      r_pc_load <= (w_state_nxt == ST_RELEASE);
      r_cpu_run <= (w_state_nxt == ST_RUN);
      r_err     <= r_err | (w_state_nxt == ST_ERR);

      if (w_hdr_acc) begin
        r_addr   <= s_data[ADDR_W-1:0];
        r_remain <= w_hdr_count;
      end

      if (w_body_acc) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= s_data;
        r_addr      <= r_addr + ADDR_W'(1);  // wraps modulo 2^ADDR_W
        r_remain    <= r_remain - CNT_W'(1);
        if (r_words != '1) r_words <= r_words + CNT_W'(1);
      end

      // Core finished: next image starts its count from zero
      if ((r_state == ST_RUN) && cpu_halted) r_words <= '0;
    end
  end

  assign s_ready      = w_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign cpu_run      = r_cpu_run;
  assign pc_load      = r_pc_load;
  assign pc_value     = ENTRY_PC;
  assign words_loaded = r_words;
  assign err          = r_err;

endmodule
